// File: rtl/bsrcl_addsub_32.sv
// Block-serial add/subtract: a single BLK-bit carry look-ahead slice is reused for
// WIDTH/BLK cycles. The carry between blocks is held in a register.
module bsrcl_addsub_32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NB   = WIDTH / BLK;
    localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_r;
    logic [IW-1:0]    r_idx;
    logic             r_c;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic [BLK-1:0]   w_g;
    logic [BLK-1:0]   w_p;
    logic [BLK-1:0]   w_c;
    logic [BLK-1:0]   w_sum;
    logic             w_gblk;
    logic             w_pblk;
    logic             w_bcout;
    logic             w_pp;
    logic             w_gg;
    logic [WIDTH-1:0] w_rnext;

    // Look-ahead carries as sum-of-products: c[i] = OR_j g[j]&p[i-1..j+1] | p[i-1..0]&cin
    always_comb begin
        w_g    = r_x[BLK-1:0] & r_y[BLK-1:0];
        w_p    = r_x[BLK-1:0] ^ r_y[BLK-1:0];
        w_c    = '0;
        w_c[0] = r_c;
        w_gblk = 1'b0;
        w_pblk = 1'b0;
        w_pp   = 1'b1;
        w_gg   = 1'b0;
        for (int unsigned i = 1; i <= BLK; i++) begin
            w_pp = 1'b1;
            w_gg = 1'b0;
            for (int unsigned n = 0; n < i; n++) begin
                w_gg = w_gg | (w_g[i-1-n] & w_pp);
                w_pp = w_pp & w_p[i-1-n];
            end
            if (i < BLK) begin
                w_c[i] = w_gg | (w_pp & r_c);
            end else begin
                w_gblk = w_gg;
                w_pblk = w_pp;
            end
        end
        w_bcout = w_gblk | (w_pblk & r_c);
        w_sum   = w_p ^ w_c;
        w_rnext = WIDTH'({w_sum, r_r} >> BLK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_c         <= 1'b0;
            r_r         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= X;
                        r_y     <= Y ^ {WIDTH{sub}};
                        r_c     <= sub;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_r   <= w_rnext;
                    r_x   <= r_x >> BLK;
                    r_y   <= r_y >> BLK;
                    r_c   <= w_bcout;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_cout      <= w_bcout;
                        r_ovf       <= w_c[BLK-1] ^ w_bcout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign R         = r_r;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

// File: doc/bsrcl_addsub_32.md
Name: bsrcl_addsub_32

Overview:
- Block-serial add/subtract unit. Time-multiplexed counterpart of the team's combinational ripple-block carry look-ahead adder.
- Uses one BLK-bit carry look-ahead slice, built from per-bit generate/propagate plus one look-ahead unit. The slice processes one block per clock and carries between blocks through a register.
- Used where area matters more than latency, e.g. address/offset arithmetic in slow control paths.
- Operands and results move over valid/ready handshakes.

Parameters:
- WIDTH, 32, operand and result width. Must be a multiple of BLK.
- BLK, 4, block width processed per cycle. The slice is a BLK-bit carry look-ahead unit.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept a request
- sub  input  1  0: X+Y, 1: X-Y; sampled on accept
- X  input  WIDTH  operand 1; sampled on accept
- Y  input  WIDTH  operand 2; sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- R  output  WIDTH  result, two's-complement wrap
- cout  output  1  carry out of MSB. For sub, 1 means X>=Y unsigned.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- NB = WIDTH/BLK. States: IDLE, RUN, DONE.
- Reset (rst high at an edge):
  - state IDLE, block index 0, carry register 0.
  - R = 0, cout = 0, ovf = 0, out_valid = 0.
  - in_ready is forced 0 while rst is high.
  - Reset in any state, including mid-RUN or DONE with result unconsumed, aborts the operation. No output is produced for it.
- in_ready = (state == IDLE) and not rst. It is combinational from state. out_valid = (state == DONE), registered.
- IDLE:
  - Accept occurs on an edge with in_valid and in_ready both high.
  - On accept, latch X and (Y XOR {WIDTH{sub}}) into operand shift registers. Carry register takes sub; index takes 0; state goes to RUN.
- RUN, each edge:
  - Slice computes G/P per bit from the low BLK bits of the operand registers.
  - Look-ahead internal carries C[1..BLK-1] come from the carry register. Block sum is P XOR carries. Block carry-out = Gblk | (Pblk & carry).
  - Sum block shifts into the result register from the top (LSB block first). Operand registers shift right by BLK. Carry register takes the block carry-out. Index increments.
  - On the edge processing block NB-1, also register cout = block carry-out and ovf = C[BLK-1] XOR block carry-out, where C[BLK-1] is the carry into the MSB. Then go to DONE.
- Latency: out_valid rises exactly NB edges after the accept edge (8 for defaults).
- DONE:
  - R, cout and ovf are stable while out_valid is high and out_ready is low.
  - On an edge with out_ready high: state goes to IDLE, out_valid drops.
  - R/cout/ovf keep their last values. They are don't-care outside DONE.
- Restrictions:
  - No accept in the same cycle as result hand-off. Back-to-back throughput is one op per NB+2 cycles.
  - in_valid, X, Y and sub are ignored outside IDLE. They may change freely during RUN/DONE.
  - out_ready outside DONE has no effect.
- Subtraction is X + ~Y + 1 via carry-in = sub. No separate borrow logic.
- BLK = WIDTH (NB = 1) is legal: one RUN cycle, then DONE.

Test Plan:
- add X=0xFFFFFFFF, Y=0x00000001, out_ready=1 -> out_valid 8 edges after accept; R=0x00000000, cout=1, ovf=0; in_ready high again one cycle later.
- sub X=5, Y=7 -> R=0xFFFFFFFE, cout=0, ovf=0. Then sub X=7, Y=5 -> R=0x00000002, cout=1, ovf=0.
- sub X=0x80000000, Y=1 -> R=0x7FFFFFFF, cout=1, ovf=1. Then add X=0x7FFFFFFF, Y=1 -> R=0x80000000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while driving in_valid=1 with new operands -> R/cout/ovf unchanged, in_ready=0, new request accepted only in the first IDLE cycle after hand-off.
- Reset mid-RUN: assert rst for 1 cycle 3 edges after accept -> out_valid stays 0, in_ready=1 the cycle after rst drops. Next op 0x12345678+0x11111111 -> R=0x23456789, cout=0.
- Random regression: 10k random ops with random in_valid/out_ready stalls, for (WIDTH,BLK) = (32,4), (16,4), (8,8) -> every result, cout and ovf match the golden add/sub model. No lost or duplicated results.
